// File: rtl/bm_dag2_pkg.sv
// Shared constants, width helper and state encoding for the bm_dag2 accumulator slice.
package bm_dag2_pkg;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = (v > 0) ? v - 1 : 0;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

  localparam int unsigned BITS_DEF     = 2;
  localparam int unsigned WINDOW_DEF   = 4;
  localparam int unsigned CNT_BITS_DEF = clog2(WINDOW_DEF) + 1;
  localparam int unsigned ACC_BITS_DEF = BITS_DEF + clog2(WINDOW_DEF);

  // Observable accumulator condition, derived from count and output occupancy
  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PARTIAL = 2'd1,
    ST_STALL   = 2'd2
  } acc_state_e;

endpackage

// File: rtl/bm_dag2_out_reg.sv
// One-entry valid/ready output register; a load may coincide with the unload of the held entry.
module bm_dag2_out_reg #(
  parameter int unsigned W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (valid_q && out_ready) valid_d = 1'b0;
    // Caller only loads when the slot is free or being drained this cycle
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/bm_dag2_accum.sv
// Windowed accumulator consuming the bm_dag2 result stream, with early flush and registered output.
// Optional saturating accumulation and out_sat flag under BM_DAG2_ACCUM_SATURATE_EN.
module bm_dag2_accum
  import bm_dag2_pkg::*;
#(
  parameter int unsigned BITS     = BITS_DEF,
  parameter int unsigned WINDOW   = WINDOW_DEF,
  parameter int unsigned CNT_BITS = clog2(WINDOW) + 1,
  parameter int unsigned ACC_BITS = BITS + clog2(WINDOW)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BITS-1:0]     in_data,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ACC_BITS-1:0] out_sum,
`ifdef BM_DAG2_ACCUM_SATURATE_EN
  output logic                out_sat,
`endif
  output logic [CNT_BITS-1:0] out_count
);

`ifdef BM_DAG2_ACCUM_SATURATE_EN
  localparam int unsigned PW = ACC_BITS + CNT_BITS + 1;
`else
  localparam int unsigned PW = ACC_BITS + CNT_BITS;
`endif

  logic [ACC_BITS-1:0] acc_q, acc_d;
  logic [CNT_BITS-1:0] count_q, count_d;
  logic                stall_c, closing_next_c, accept_c, close_c;
  logic [ACC_BITS-1:0] sum_c;
  logic [CNT_BITS-1:0] count_nx_c;
  logic [PW-1:0]       payload_c, out_data;
  acc_state_e          state_c;
`ifdef BM_DAG2_ACCUM_SATURATE_EN
  logic                sat_q, sat_d, sat_nx_c;
  logic [ACC_BITS:0]   wide_c;
`endif

  always_comb begin
    stall_c        = out_valid && !out_ready;
    closing_next_c = (count_q == CNT_BITS'(WINDOW - 1)) ||
                     (flush && ((count_q != '0) || in_valid));
    // Only a closing sample must wait for the output slot
    in_ready       = !(stall_c && closing_next_c);
    accept_c       = in_valid && in_ready;
    count_nx_c     = count_q + CNT_BITS'(accept_c);
`ifdef BM_DAG2_ACCUM_SATURATE_EN
    wide_c   = {1'b0, acc_q} + (accept_c ? (ACC_BITS + 1)'(in_data) : '0);
    sum_c    = wide_c[ACC_BITS] ? '1 : wide_c[ACC_BITS-1:0];
    sat_nx_c = sat_q | wide_c[ACC_BITS];
`else
    sum_c    = acc_q + (accept_c ? ACC_BITS'(in_data) : '0);
`endif
    // A flush that finds the output stalled is dropped, not remembered
    close_c = !stall_c &&
              ((accept_c && (count_nx_c == CNT_BITS'(WINDOW))) ||
               (flush && (count_nx_c != '0)));
    acc_d   = close_c ? '0 : sum_c;
    count_d = close_c ? '0 : count_nx_c;
`ifdef BM_DAG2_ACCUM_SATURATE_EN
    sat_d     = close_c ? 1'b0 : sat_nx_c;
    payload_c = {sat_nx_c, count_nx_c, sum_c};
`else
    payload_c = {count_nx_c, sum_c};
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q   <= '0;
      count_q <= '0;
`ifdef BM_DAG2_ACCUM_SATURATE_EN
      sat_q   <= 1'b0;
`endif
    end else begin
      acc_q   <= acc_d;
      count_q <= count_d;
`ifdef BM_DAG2_ACCUM_SATURATE_EN
      sat_q   <= sat_d;
`endif
    end
  end

  bm_dag2_out_reg #(.W(PW)) u_out_reg (
    .clock     (clock),
    .reset     (reset),
    .load      (close_c),
    .load_data (payload_c),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  assign out_sum   = out_data[ACC_BITS-1:0];
  assign out_count = out_data[ACC_BITS +: CNT_BITS];
`ifdef BM_DAG2_ACCUM_SATURATE_EN
  assign out_sat   = out_data[PW-1];
`endif

  always_comb begin
    if (stall_c && closing_next_c) state_c = ST_STALL;
    else if (count_q == '0)        state_c = ST_EMPTY;
    else                           state_c = ST_PARTIAL;
  end

  a_stall_blocks_input: assert property (@(posedge clock) disable iff (reset)
    (state_c == ST_STALL) |-> !in_ready);
  a_count_in_range: assert property (@(posedge clock) disable iff (reset)
    count_q < CNT_BITS'(WINDOW));

endmodule

// File: tb/tb_bm_dag2_accum.sv
// Directed self-checking bench for bm_dag2_accum (default widths plus a narrow ACC_BITS=3 instance).
module tb_bm_dag2_accum;

  logic       clock = 1'b0;
  logic       reset;
  logic       in_valid, flush, out_ready;
  logic       in_ready, out_valid;
  logic [1:0] in_data;
  logic [3:0] out_sum;
  logic [2:0] out_count;

  logic       w_in_valid, w_out_ready, w_in_ready, w_out_valid;
  logic [1:0] w_in_data;
  logic [2:0] w_out_sum;
  logic [2:0] w_out_count;
`ifdef BM_DAG2_ACCUM_SATURATE_EN
  logic       out_sat, w_out_sat;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  bm_dag2_accum u_dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
`ifdef BM_DAG2_ACCUM_SATURATE_EN
    .out_sat   (out_sat),
`endif
    .out_count (out_count)
  );

  bm_dag2_accum #(.ACC_BITS(3)) u_dut_w (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (w_in_valid),
    .in_ready  (w_in_ready),
    .in_data   (w_in_data),
    .flush     (1'b0),
    .out_valid (w_out_valid),
    .out_ready (w_out_ready),
    .out_sum   (w_out_sum),
`ifdef BM_DAG2_ACCUM_SATURATE_EN
    .out_sat   (w_out_sat),
`endif
    .out_count (w_out_count)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one active edge; inputs are then changed 1 time unit after it
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [3:0] s, input logic [2:0] c);
    check_val({tag, "_valid"}, 32'(out_valid), 32'(v));
    if (v) begin
      check_val({tag, "_sum"}, 32'(out_sum), 32'(s));
      check_val({tag, "_count"}, 32'(out_count), 32'(c));
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b1;
    w_in_valid = 1'b0; w_in_data = '0; w_out_ready = 1'b1;
    tick(); tick();
    reset = 1'b0;
    check_val("rst_valid", 32'(out_valid), 0);
    check_val("rst_sum", 32'(out_sum), 0);
    check_val("rst_count", 32'(out_count), 0);
    check_val("rst_in_ready", 32'(in_ready), 1);

    // Full window 3,2,1,3
    send(2'd3); send(2'd2); send(2'd1);
    check_val("full_pre_valid", 32'(out_valid), 0);
    send(2'd3);
    check_out("full", 1'b1, 4'd9, 3'd4);
    tick();
    check_val("full_pulse_end", 32'(out_valid), 0);

    // Early flush after 2,3; then flush with nothing held
    send(2'd2); send(2'd3);
    flush = 1'b1; tick(); flush = 1'b0;
    check_out("flush", 1'b1, 4'd5, 3'd2);
    tick();
    check_val("flush_drain", 32'(out_valid), 0);
    flush = 1'b1; tick(); flush = 1'b0;
    check_val("flush_empty", 32'(out_valid), 0);
    tick();
    check_val("flush_empty2", 32'(out_valid), 0);

    // Stall with load-while-unload
    out_ready = 1'b0;
    send(2'd1); send(2'd1); send(2'd1); send(2'd1);
    check_out("stall_w1", 1'b1, 4'd4, 3'd4);
    in_valid = 1'b1; in_data = 2'd2; #1;
    check_val("stall_nonclose_ready", 32'(in_ready), 1);
    tick(); tick(); tick();
    check_val("stall_ready_low", 32'(in_ready), 0);
    tick();
    check_out("stall_hold", 1'b1, 4'd4, 3'd4);
    out_ready = 1'b1; #1;
    check_val("stall_ready_rel", 32'(in_ready), 1);
    tick(); in_valid = 1'b0;
    check_out("stall_b2b", 1'b1, 4'd8, 3'd4);
    tick();
    check_val("stall_drain", 32'(out_valid), 0);

    // Flush together with a sample
    send(2'd1); send(2'd1);
    in_valid = 1'b1; in_data = 2'd3; flush = 1'b1;
    tick(); in_valid = 1'b0; flush = 1'b0;
    check_out("flush_smp", 1'b1, 4'd5, 3'd3);
    tick();

    // Flush while stalled is dropped
    out_ready = 1'b0;
    send(2'd1); send(2'd1); send(2'd1); send(2'd1);
    send(2'd2);
    flush = 1'b1; #1;
    check_val("stflush_ready", 32'(in_ready), 0);
    tick(); flush = 1'b0;
    check_out("stflush_hold", 1'b1, 4'd4, 3'd4);
    out_ready = 1'b1; tick();
    check_val("stflush_dropped", 32'(out_valid), 0);
    flush = 1'b1; tick(); flush = 1'b0;
    check_out("stflush_retry", 1'b1, 4'd2, 3'd1);
    tick();

    // Reset mid-window with output held
    out_ready = 1'b0;
    send(2'd1); send(2'd1); send(2'd1); send(2'd1);
    send(2'd1); send(2'd1); send(2'd1);
    reset = 1'b1; tick(); reset = 1'b0;
    check_val("rst_mid_valid", 32'(out_valid), 0);
    check_val("rst_mid_sum", 32'(out_sum), 0);
    out_ready = 1'b1;
    send(2'd1); send(2'd1); send(2'd1);
    check_val("rst_mid_nostale", 32'(out_valid), 0);
    send(2'd1);
    check_out("rst_mid_next", 1'b1, 4'd4, 3'd4);
    tick();

    // Narrow accumulator: 3,3,3,3 wraps to 4 or clips to 7
    for (int i = 0; i < 4; i++) begin
      w_in_valid = 1'b1; w_in_data = 2'd3; tick();
    end
    w_in_valid = 1'b0;
    check_val("narrow_valid", 32'(w_out_valid), 1);
    check_val("narrow_count", 32'(w_out_count), 4);
`ifdef BM_DAG2_ACCUM_SATURATE_EN
    check_val("narrow_sum", 32'(w_out_sum), 7);
    check_val("narrow_sat", 32'(w_out_sat), 1);
`else
    check_val("narrow_sum", 32'(w_out_sum), 4);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
